// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I load/store funct3 codes, the response cause codes and the
// FSM state encoding. The RTL files and the testbench import it.
package lsu_pkg;

  // RV32I funct3 encodings for loads and stores. Stores use only B/H/W.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_TIMEOUT  = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    RESP,
    ERR
  } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide request/grant/rvalid data-memory bus.
//   req/we/addr/wstrb/wdata : driven by the load/store unit (master)
//   gnt                     : memory accepted the request this cycle
//   rvalid/rdata            : read data returned by memory
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wstrb, wdata,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, wstrb, wdata,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational datapath helper for the load/store unit.
// Request side (live executor request):
//   req_write, req_funct3, req_off, req_wdata in
//   req_wstrb, req_wdata_lane            out : store byte strobes / lane data
//   illegal, misaligned                  out : request checks (illegal wins)
// Load side (latched request + returned word):
//   ld_funct3, ld_off, ld_rdata in ; ld_data out : extracted, extended data
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata_lane,
  output logic        illegal,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    illegal        = 1'b0;
    misaligned     = 1'b0;
    req_wstrb      = 4'b1111;
    req_wdata_lane = req_wdata;
    ld_data        = ld_rdata;

    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_write;  // no unsigned stores
      default:          illegal = 1'b1;
    endcase

    // Alignment is only judged for legal encodings, so illegal takes priority.
    if (!illegal) begin
      case (req_funct3[1:0])
        2'b01:   misaligned = req_off[0];
        2'b10:   misaligned = (req_off != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end

    // Replicating the data across lanes lets the strobes alone pick the bytes.
    case (req_funct3[1:0])
      2'b00: begin
        req_wstrb      = 4'b0001 << req_off;
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_wstrb      = 4'b0011 << req_off;
        req_wdata_lane = {2{req_wdata[15:0]}};
      end
      default: begin
        req_wstrb      = 4'b1111;
        req_wdata_lane = req_wdata;
      end
    endcase

    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: takes one load/store request from the executor, runs it
// on the data-memory bus and returns extended load data or an error cause.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata  : request fields
//   resp_valid                   : one-cycle completion pulse
//   resp_rdata/resp_err/cause    : result, zero unless resp_valid
//   mem                          : data-memory bus (master side)
// TIMEOUT_CYCLES bounds the wait for gnt or rvalid (0 disables); it must be
// below 2**CNT_W.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [1:0]                resp_cause,
  load_store_unit_if.master         mem
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_wstrb_q;
  logic [31:0]      mem_wdata_q;

  logic [3:0]       wstrb;
  logic [31:0]      wdata_lane;
  logic             illegal;
  logic             misaligned;
  logic [31:0]      ld_data;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  lsu_align u_align (
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_off        (req_addr[1:0]),
    .req_wdata      (req_wdata),
    .req_wstrb      (wstrb),
    .req_wdata_lane (wdata_lane),
    .illegal        (illegal),
    .misaligned     (misaligned),
    .ld_funct3      (funct3_q),
    .ld_off         (off_q),
    .ld_rdata       (mem.rdata),
    .ld_data        (ld_data)
  );

  // Timeout fires on the cycle whose increment would reach the limit, so the
  // registered error shows up exactly TIMEOUT_CYCLES cycles after entry.
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIMIT);

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wstrb = mem_wstrb_q;
  assign mem.wdata = mem_wdata_q;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // read in this block sees the value from before the edge; reset is sampled
  // on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      resp_cause  <= CAUSE_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Response outputs are single-cycle pulses; set only on entry to RESP/ERR.
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_cause <= CAUSE_NONE;

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            if (illegal || misaligned) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state       <= REQ;
              cnt         <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_write;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wstrb_q <= req_write ? wstrb : 4'b0000;
              mem_wdata_q <= req_write ? wdata_lane : 32'h0;
            end
          end
        end

        REQ: begin
          if (mem.gnt || timeout_hit) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
          end
          // A grant on the timeout cycle still counts: the bus took it.
          if (mem.gnt) begin
            cnt <= '0;
            if (mem_we_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT_R;
            end
          end else if (timeout_hit) begin
            state      <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt_inc;
          end
        end

        WAIT_R: begin
          if (mem.rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end else if (timeout_hit) begin
            state      <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt_inc;
          end
        end

        RESP, ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Table of transactions with a bench-side memory responder; expected responses
// go through a scoreboard queue, plus hand-written reset and stray-rvalid cases.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int NEVER = 99;

  typedef struct {
    string       name;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [31:0] e_maddr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    int          e_req_cyc;
    int          e_lat;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [1:0]  e_cause;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_cause;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_cause (resp_cause),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept on the posedge after the first negedge; cycle k = k-th cycle after.
  task automatic run_vec(input vec_t v);
    int   gnt_cyc;
    int   rv_cyc;
    int   req_cyc;
    bit   done;
    exp_t e;
    gnt_cyc = 1 + v.gnt_dly;
    rv_cyc  = gnt_cyc + 1 + v.rv_dly;
    req_cyc = 0;
    done    = 1'b0;
    @(negedge clk);
    check({v.name, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = v.write;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    sb.push_back('{v.e_rdata, v.e_err, v.e_cause});
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_bus.req) begin
        req_cyc++;
        check({v.name, " mem_addr"},  mem_bus.addr,         v.e_maddr);
        check({v.name, " mem_we"},    32'(mem_bus.we),      32'(v.write));
        check({v.name, " mem_wstrb"}, 32'(mem_bus.wstrb),   32'(v.e_wstrb));
        check({v.name, " mem_wdata"}, mem_bus.wdata,        v.e_wdata);
      end
      check({v.name, " ready_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) begin
        done = 1'b1;
        check({v.name, " latency"},   32'(k),       32'(v.e_lat));
        check({v.name, " req_cycles"}, 32'(req_cyc), 32'(v.e_req_cyc));
        if (sb.size() == 0) begin
          check({v.name, " unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({v.name, " resp_rdata"}, resp_rdata,       e.rdata);
          check({v.name, " resp_err"},   32'(resp_err),    32'(e.err));
          check({v.name, " resp_cause"}, 32'(resp_cause),  32'(e.cause));
        end
      end
      mem_bus.gnt    = !done && (k == gnt_cyc);
      mem_bus.rvalid = !done && (k == rv_cyc);
      mem_bus.rdata  = v.rdata;
    end
    if (!done) begin
      check({v.name, " resp_within_bound"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_back());
    end
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b0;
  endtask

  // Late read data after a timeout must not produce a response.
  task automatic stray_rvalid();
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray resp_valid", 32'(resp_valid), 32'd0);
      check("stray resp_rdata", resp_rdata,      32'd0);
      check("stray req_ready",  32'(req_ready),  32'd1);
    end
    mem_bus.rvalid = 1'b0;
  endtask

  initial begin
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;

    // name, we, f3, addr, wdata, gnt_dly, rv_dly, rdata,
    // e_maddr, e_wstrb, e_wdata, e_req_cyc, e_lat, e_rdata, e_err, e_cause
    vq.push_back('{"sb_1003",   1'b1, F3_B,   32'h1003, 32'h0000_00A5, 0, 0, 32'h0,
                   32'h1000, 4'b1000, 32'hA5A5_A5A5, 1, 2, 32'h0, 1'b0, 2'd0});
    vq.push_back('{"lh_2002",   1'b0, F3_H,   32'h2002, 32'h0, 0, 0, 32'h8001_1234,
                   32'h2000, 4'b0000, 32'h0, 1, 3, 32'hFFFF_8001, 1'b0, 2'd0});
    vq.push_back('{"lhu_2002",  1'b0, F3_HU,  32'h2002, 32'h0, 0, 0, 32'h8001_1234,
                   32'h2000, 4'b0000, 32'h0, 1, 3, 32'h0000_8001, 1'b0, 2'd0});
    vq.push_back('{"lb_2001",   1'b0, F3_B,   32'h2001, 32'h0, 0, 0, 32'h8001_1234,
                   32'h2000, 4'b0000, 32'h0, 1, 3, 32'h0000_0012, 1'b0, 2'd0});
    vq.push_back('{"lb_2003",   1'b0, F3_B,   32'h2003, 32'h0, 0, 0, 32'h8001_1234,
                   32'h2000, 4'b0000, 32'h0, 1, 3, 32'hFFFF_FF80, 1'b0, 2'd0});
    vq.push_back('{"lbu_2003",  1'b0, F3_BU,  32'h2003, 32'h0, 0, 0, 32'h8001_1234,
                   32'h2000, 4'b0000, 32'h0, 1, 3, 32'h0000_0080, 1'b0, 2'd0});
    vq.push_back('{"lh_2000",   1'b0, F3_H,   32'h2000, 32'h0, 0, 0, 32'h8001_1234,
                   32'h2000, 4'b0000, 32'h0, 1, 3, 32'h0000_1234, 1'b0, 2'd0});
    vq.push_back('{"lw_mis",    1'b0, F3_W,   32'h3006, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 0, 1, 32'h0, 1'b1, 2'd1});
    vq.push_back('{"ld_f3_011", 1'b0, 3'b011, 32'h3000, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 0, 1, 32'h0, 1'b1, 2'd3});
    vq.push_back('{"st_f3_100", 1'b1, 3'b100, 32'h3000, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 0, 1, 32'h0, 1'b1, 2'd3});
    vq.push_back('{"ill_prio",  1'b0, 3'b011, 32'h3001, 32'h0, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 0, 1, 32'h0, 1'b1, 2'd3});
    vq.push_back('{"sh_1002",   1'b1, F3_H,   32'h1002, 32'h0000_BEEF, 1, 0, 32'h0,
                   32'h1000, 4'b1100, 32'hBEEF_BEEF, 2, 3, 32'h0, 1'b0, 2'd0});
    vq.push_back('{"sh_mis",    1'b1, F3_H,   32'h1001, 32'h0000_BEEF, 0, 0, 32'h0,
                   32'h0, 4'b0000, 32'h0, 0, 1, 32'h0, 1'b1, 2'd1});
    vq.push_back('{"sw_4000",   1'b1, F3_W,   32'h4000, 32'hDEAD_BEEF, 2, 0, 32'h0,
                   32'h4000, 4'b1111, 32'hDEAD_BEEF, 3, 4, 32'h0, 1'b0, 2'd0});
    vq.push_back('{"lw_4000",   1'b0, F3_W,   32'h4000, 32'h0, 2, 0, 32'hDEAD_BEEF,
                   32'h4000, 4'b0000, 32'h0, 3, 5, 32'hDEAD_BEEF, 1'b0, 2'd0});
    vq.push_back('{"lw_rvdly",  1'b0, F3_W,   32'h5000, 32'h0, 1, 2, 32'h1234_5678,
                   32'h5000, 4'b0000, 32'h0, 2, 6, 32'h1234_5678, 1'b0, 2'd0});
    vq.push_back('{"sw_to_gnt", 1'b1, F3_W,   32'h6000, 32'h0BAD_F00D, NEVER, 0, 32'h0,
                   32'h6000, 4'b1111, 32'h0BAD_F00D, 4, 5, 32'h0, 1'b1, 2'd2});
    vq.push_back('{"lw_to_rv",  1'b0, F3_W,   32'h7000, 32'h0, 0, NEVER, 32'h0,
                   32'h7000, 4'b0000, 32'h0, 1, 6, 32'h0, 1'b1, 2'd2});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",  32'(req_ready),      32'd1);
    check("rst resp_valid", 32'(resp_valid),     32'd0);
    check("rst resp_cause", 32'(resp_cause),     32'd0);
    check("rst mem_req",    32'(mem_bus.req),    32'd0);
    check("rst mem_wstrb",  32'(mem_bus.wstrb),  32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      run_vec(vq[i]);
      if (vq[i].e_cause == 2'd2) stray_rvalid();
    end

    // Reset while a load sits in WAIT_R.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h4000;
    @(negedge clk);
    req_valid   = 1'b0;
    check("rstmid mem_req_c1", 32'(mem_bus.req), 32'd1);
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    mem_bus.gnt = 1'b0;
    check("rstmid in_wait", 32'(mem_bus.req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid req_ready",  32'(req_ready),   32'd1);
    check("rstmid mem_req",    32'(mem_bus.req), 32'd0);
    check("rstmid resp_valid", 32'(resp_valid),  32'd0);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid no_resp", 32'(resp_valid), 32'd0);
    end
    mem_bus.rvalid = 1'b0;
    run_vec(vq[1]);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
